// File: rtl/chaser_pkg.sv
// Shared definitions for the LED chaser input stage: button FSM encoding,
// synchronizer depth and the board-clock debounce default.
package chaser_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int SYNC_STAGES = 2;

  // 10 ms at a 100 MHz board clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw button source and the conditioned outputs.
// raw_btn is driven by the button side; the remaining signals are strobes and
// levels produced by the conditioner, all valid in the clk domain.
interface button_conditioner_if;

  logic raw_btn;
  logic btn_stable;
  logic press_pulse;
  logic release_pulse;
  logic run_level;

  modport master (
    output raw_btn,
    input  btn_stable,
    input  press_pulse,
    input  release_pulse,
    input  run_level
  );

  modport slave (
    input  raw_btn,
    output btn_stable,
    output press_pulse,
    output release_pulse,
    output run_level
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input into the clk domain.
// Reusable for any other asynchronous switch input of the chaser.
module sync_2ff
  import chaser_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push-button and produces a stable level, press/release
// strobes and a run level that toggles on each accepted press.
module button_conditioner
  import chaser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_btn,
    output logic btn_stable,
    output logic press_pulse,
    output logic release_pulse,
    output logic run_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_in;
    logic             s;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             run_q, run_d;

    // Polarity is normalised before synchronizing so the FSM always sees 1 = pressed.
    assign btn_in = BTN_ACTIVE_LOW ? ~raw_btn : raw_btn;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            run_q     <= run_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        run_d     = run_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    run_d   = ~run_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The button counts as pressed from acceptance until the release is accepted.
    assign btn_stable    = (state_q == HELD) || (state_q == RELEASE_CHK);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign run_level     = run_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance
// driven in lockstep, checked against hand tables and a debounce model.
module tb_button_conditioner;

  localparam int DC = 4;

  typedef struct {
    bit         rst;
    bit         raw;
    logic [3:0] exp;  // {btn_stable, press_pulse, release_pulse, run_level}
  } vec_t;

  logic clk = 1'b0;
  logic reset_s = 1'b1;
  logic raw_b = 1'b0;
  logic b_stable, b_press, b_release, b_run;

  button_conditioner_if bif ();

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  vec_t tbl[$];

  // Model state per instance: 2-deep input delay, accepted level, run length
  // of disagreeing samples, toggle level.
  bit hist[2][2];
  bit lvl[2];
  int runlen[2];
  bit rl[2];

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(20), .BTN_ACTIVE_LOW(1'b0)) dut_a (
    .clk           (clk),
    .reset         (reset_s),
    .raw_btn       (bif.raw_btn),
    .btn_stable    (bif.btn_stable),
    .press_pulse   (bif.press_pulse),
    .release_pulse (bif.release_pulse),
    .run_level     (bif.run_level)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(20), .BTN_ACTIVE_LOW(1'b1)) dut_b (
    .clk           (clk),
    .reset         (reset_s),
    .raw_btn       (raw_b),
    .btn_stable    (b_stable),
    .press_pulse   (b_press),
    .release_pulse (b_release),
    .run_level     (b_run)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, required the test to finish first");
    $fatal(1, "watchdog");
  end

  // A change is accepted once the synchronized input has disagreed with the
  // accepted level on DC+1 consecutive edges.
  task automatic model_step(input int i, input bit rst, input bit pressed, output logic [3:0] y);
    bit s, p, r;
    p = 1'b0;
    r = 1'b0;
    if (rst) begin
      hist[i][0] = 1'b0;
      hist[i][1] = 1'b0;
      lvl[i] = 1'b0;
      runlen[i] = 0;
      rl[i] = 1'b0;
    end else begin
      s = hist[i][0];
      hist[i][0] = hist[i][1];
      hist[i][1] = pressed;
      if (s != lvl[i]) runlen[i] = runlen[i] + 1;
      else runlen[i] = 0;
      if (runlen[i] == DC + 1) begin
        lvl[i] = s;
        runlen[i] = 0;
        if (s) begin
          p = 1'b1;
          rl[i] = ~rl[i];
        end else begin
          r = 1'b1;
        end
      end
    end
    y = {lvl[i], p, r, rl[i]};
  endtask

  // scoreboard
  task automatic check(input string name);
    logic [7:0] exp, act;
    exp = exp_q.pop_front();
    act = {bif.btn_stable, bif.press_pulse, bif.release_pulse, bif.run_level,
           b_stable, b_press, b_release, b_run};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b_%b required %b_%b", name, $time,
               act[7:4], act[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  // driver: raw_a is the active-high button, raw_bb the active-low one
  task automatic tick(input bit rst, input bit raw_a, input bit raw_bb,
                      input bit use_tbl, input logic [3:0] tbl_exp, input string name);
    logic [3:0] ya, yb;
    reset_s = rst;
    bif.raw_btn = raw_a;
    raw_b = raw_bb;
    model_step(0, rst, raw_a, ya);
    model_step(1, rst, ~raw_bb, yb);
    if (use_tbl) exp_q.push_back({tbl_exp, tbl_exp});
    else exp_q.push_back({ya, yb});
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic add(input int n, input bit rst, input bit raw, input logic [3:0] exp);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.rst = rst;
      v.raw = raw;
      v.exp = exp;
      tbl.push_back(v);
    end
  endtask

  initial begin
    bif.raw_btn = 1'b1;
    raw_b = 1'b0;
    // reset with button pressed, then press accepted on edge 7
    add(3, 1, 1, 4'b0000);
    add(6, 0, 1, 4'b0000); add(1, 0, 1, 4'b1101); add(2, 0, 1, 4'b1001);
    // release
    add(6, 0, 0, 4'b1001); add(1, 0, 0, 4'b0011); add(2, 0, 0, 4'b0001);
    // bounce 1,1,0 then steady 1: one press, run_level back to 0
    add(2, 0, 1, 4'b0001); add(1, 0, 0, 4'b0001);
    add(6, 0, 1, 4'b0001); add(1, 0, 1, 4'b1100); add(2, 0, 1, 4'b1000);
    add(6, 0, 0, 4'b1000); add(1, 0, 0, 4'b0010); add(2, 0, 0, 4'b0000);
    // press to run_level=1, then reset while HELD
    add(6, 0, 1, 4'b0000); add(1, 0, 1, 4'b1101); add(2, 0, 1, 4'b1001);
    add(1, 1, 1, 4'b0000);
    add(6, 0, 1, 4'b0000); add(1, 0, 1, 4'b1101); add(1, 0, 1, 4'b1001);
    // release, then reset while PRESS_CHK with counter=2
    add(6, 0, 0, 4'b1001); add(1, 0, 0, 4'b0011); add(2, 0, 0, 4'b0001);
    add(5, 0, 1, 4'b0001); add(1, 1, 1, 4'b0000); add(8, 0, 0, 4'b0000);

    foreach (tbl[i]) tick(tbl[i].rst, tbl[i].raw, ~tbl[i].raw, 1'b1, tbl[i].exp, "table");

    // hand sequence: reset during RELEASE_CHK gives no release pulse
    for (int k = 0; k < 12; k++) tick(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, "rel_chk_reset");
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, "rel_chk_reset");
    tick(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "rel_chk_reset");
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, "rel_chk_reset");

    // randomized bouncing runs with independent buttons and rare resets
    begin
      bit ra, rb, rst;
      int len_a, len_b;
      ra = 1'b0; rb = 1'b1; len_a = 0; len_b = 0;
      for (int k = 0; k < 3000; k++) begin
        if (len_a == 0) begin ra = ~ra; len_a = $urandom_range(1, 12); end
        if (len_b == 0) begin rb = ~rb; len_b = $urandom_range(1, 12); end
        len_a--; len_b--;
        rst = ($urandom_range(0, 199) == 0);
        tick(rst, ra, rb, 1'b0, 4'b0000, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the LED chaser.
- Takes one raw, asynchronous, bouncing push-button.
- Produces a clean debounced level, single-cycle press/release pulses, and a run level that toggles on every press.
- run_level drives the chaser's run input; press_pulse can drive any step/mode input.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronized samples required to accept a change (10 ms at 100 MHz); legal range 1 .. 2^CNT_W-1.
- CNT_W, 20, debounce counter width.
- BTN_ACTIVE_LOW, 0, 1 = raw_btn is pressed when 0; the input is inverted before the synchronizer.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_btn  input  1  asynchronous bouncing button input.
- btn_stable  output  1  debounced pressed level.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- run_level  output  1  toggles on every press_pulse.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. There is no asynchronous path anywhere.
- Reset:
  - Sync flops = 0, state = IDLE, counter = 0.
  - btn_stable = 0, press_pulse = 0, release_pulse = 0, run_level = 0.
  - Reset has priority over every other event in the same cycle.
- Synchronizer:
  - Two flops. The synced value s reflects raw_btn (after polarity inversion) sampled 2 edges earlier.
  - The FSM sees only s, never raw_btn.
- FSM states (2-bit): IDLE, PRESS_CHK, HELD, RELEASE_CHK.
- IDLE:
  - s=1 -> PRESS_CHK, counter <= 0.
  - Otherwise stay.
- PRESS_CHK:
  - s=0 -> IDLE, counter <= 0 (bounce rejected, no pulse).
  - s=1 and counter == DEBOUNCE_CYCLES-1 -> HELD, press_pulse <= 1, run_level <= ~run_level.
  - Otherwise counter <= counter+1.
- HELD:
  - s=0 -> RELEASE_CHK, counter <= 0.
  - Otherwise stay.
- RELEASE_CHK:
  - s=1 -> HELD, counter <= 0 (bounce rejected).
  - s=0 and counter == DEBOUNCE_CYCLES-1 -> IDLE, release_pulse <= 1.
  - Otherwise counter <= counter+1.
- Outputs:
  - btn_stable is 1 exactly when state is HELD or RELEASE_CHK. It is registered and decoded from the state register only.
  - press_pulse and release_pulse are registered, high for exactly one cycle, and default to 0 every other cycle.
  - press_pulse and release_pulse are never high in the same cycle.
- Latency:
  - Raw press held stable from edge 1 -> press_pulse and btn_stable high after edge DEBOUNCE_CYCLES+3.
  - Release latency is identical.
- Counter:
  - Unsigned, CNT_W bits.
  - Never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.
  - Cleared on every state entry.
- DEBOUNCE_CYCLES=1: a change is accepted on the first PRESS_CHK/RELEASE_CHK cycle where s is still at the new value.
- Reset mid-debounce or while HELD: the next edge returns the block to IDLE with all outputs 0. No pulse is emitted and run_level is forced to 0.
- Continuous holding: no repeat pulses; exactly one press_pulse per accepted press.

Decomposition:
- Shared package (chaser_pkg):
  - FSM state localparams: IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, RELEASE_CHK=2'd3.
  - SYNC_STAGES=2.
  - Default DEBOUNCE_CYCLES for the board clock.
- Sub-module sync_2ff:
  - Ports: clk, reset, d, q.
  - Reusable for the chaser's other asynchronous switch inputs.
- FSM, counter and output registers stay in button_conditioner.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset held 3 cycles with raw_btn=1 -> all outputs 0 during reset, state IDLE; after release, press_pulse at edge 7 counted from the first edge with reset low.
- Clean press: raw_btn 0->1 at edge 1, held -> press_pulse=1 only after edge 7, btn_stable=1 from edge 7, run_level 0->1.
- Bounce: raw_btn pattern 1,1,0,1,1,1,1,1 -> no pulse at the first attempt; press_pulse exactly once, 7 edges after the last 0->1 transition.
- Release then second press -> release_pulse one cycle 7 edges after the release, btn_stable=0; second press returns run_level 1->0.
- Reset asserted while in PRESS_CHK (counter=2) -> no press_pulse, IDLE next edge; reset asserted in HELD with run_level=1 -> run_level=0 and btn_stable=0 next edge.
- BTN_ACTIVE_LOW=1, raw_btn held 0 -> press_pulse after edge 7; raw_btn=1 -> release_pulse after 7 edges.
